eif_neuron_scheduler: RTL and testbench

Time-multiplexed controller that shares one exponential-integrate-and-fire update datapath among `N_NEURONS` virtual neurons. On each `tick` it sweeps every neuron in index order: it issues that neuron's stored membrane state and input current to the shared datapath, waits for the result, writes the new state back, and emits a spike event on a valid/ready port. It sits between the stimulus/config logic and the single neuron update core, and owns all per-neuron state storage.

---
 rtl/eif_neuron_scheduler_if.sv | 27 ++
 rtl/eif_neuron_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_eif_neuron_scheduler.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eif_neuron_scheduler_if.sv
// Datapath request/response and spike-event handshake bundle for
// eif_neuron_scheduler. The master side is the scheduler; the slave side
// is the shared neuron update core together with the spike consumer.
interface eif_neuron_scheduler_if #(
    parameter int ID_W = 2,
    parameter int W    = 8
) ();
    logic            req_valid;
    logic [W-1:0]    req_state;
    logic [W-1:0]    req_current;
    logic            resp_valid;
    logic [W-1:0]    resp_state;
    logic            resp_spike;
    logic            spike_valid;
    logic [ID_W-1:0] spike_id;
    logic            spike_ready;

    modport master (
        output req_valid, req_state, req_current, spike_valid, spike_id,
        input  resp_valid, resp_state, resp_spike, spike_ready
    );

    modport slave (
        input  req_valid, req_state, req_current, spike_valid, spike_id,
        output resp_valid, resp_state, resp_spike, spike_ready
    );
endinterface

// File: rtl/eif_neuron_scheduler.sv
// Time-multiplexed sweep controller sharing one EIF update datapath among
// N_NEURONS virtual neurons. Owns the per-neuron membrane state and input
// current tables. Optional feature macro: EIF_SCHED_REFRACTORY_EN adds a
// per-neuron refractory counter that skips a neuron for REFRAC_TICKS sweeps
// after it spikes.
module eif_neuron_scheduler #(
    parameter int N_NEURONS    = 4,
    parameter int ID_W         = 2,
    parameter int W            = 8,
    parameter int U_REST       = 50,
    parameter int REFRAC_TICKS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           cur_we,
    input  logic [ID_W-1:0]                cur_addr,
    input  logic [W-1:0]                   cur_data,
    eif_neuron_scheduler_if.master         bus,
    output logic                           busy,
    output logic                           done,
    output logic                           tick_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          st;
    logic [W-1:0]    state_mem [N_NEURONS];
    logic [W-1:0]    cur_mem   [N_NEURONS];
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] nidx;
    logic            last;
    logic [W-1:0]    resp_state_q;
    logic            resp_spike_q;
    logic            skip_cur;
    logic            issue_first;
    logic            issue_next;
    logic            advance;

    assign nidx = idx + ID_W'(1);
    assign last = (idx == ID_W'(N_NEURONS - 1));

`ifdef EIF_SCHED_REFRACTORY_EN
    localparam int RC_W = (REFRAC_TICKS > 1) ? $clog2(REFRAC_TICKS + 1) : 1;
    logic [RC_W-1:0] refr [N_NEURONS];

    assign skip_cur    = (refr[idx] != '0);
    assign issue_first = (refr[0] == '0);
    assign issue_next  = (refr[nidx] == '0);
`else
    logic unused_refrac;

    assign unused_refrac = ^REFRAC_TICKS;
    assign skip_cur      = 1'b0;
    assign issue_first   = 1'b1;
    assign issue_next    = 1'b1;
`endif

    // Step to the next neuron (or finish the sweep) this cycle.
    always_comb begin
        advance = 1'b0;
        case (st)
            S_ISSUE: advance = skip_cur;
            S_WRITE: advance = !resp_spike_q;
            S_EMIT:  advance = bus.spike_ready;
            default: advance = 1'b0;
        endcase
    end

    // Input current table; writable in any FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                cur_mem[i] <= '0;
            end
        end else if (cur_we) begin
            cur_mem[cur_addr] <= cur_data;
        end
    end

    // Sweep FSM with registered outputs and membrane state write-back.
    // The request registers are loaded on the edge that enters ISSUE, so a
    // current write landing during ISSUE only affects the next sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st              <= S_IDLE;
            idx             <= '0;
            bus.req_valid   <= 1'b0;
            bus.req_state   <= '0;
            bus.req_current <= '0;
            bus.spike_valid <= 1'b0;
            bus.spike_id    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            tick_overrun    <= 1'b0;
            resp_state_q    <= '0;
            resp_spike_q    <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                state_mem[i] <= W'(U_REST);
`ifdef EIF_SCHED_REFRACTORY_EN
                refr[i] <= '0;
`endif
            end
        end else begin
            done <= 1'b0;
            if (tick && st != S_IDLE) begin
                tick_overrun <= 1'b1;
            end

            case (st)
                S_IDLE: begin
                    if (tick) begin
                        st              <= S_ISSUE;
                        idx             <= '0;
                        busy            <= 1'b1;
                        bus.req_valid   <= issue_first;
                        bus.req_state   <= state_mem[0];
                        bus.req_current <= cur_mem[0];
                    end
                end
                S_ISSUE: begin
                    bus.req_valid <= 1'b0;
                    if (!skip_cur) begin
                        st <= S_WAIT;
                    end
`ifdef EIF_SCHED_REFRACTORY_EN
                    else begin
                        refr[idx] <= refr[idx] - RC_W'(1);
                    end
`endif
                end
                S_WAIT: begin
                    if (bus.resp_valid) begin
                        resp_state_q <= bus.resp_state;
                        resp_spike_q <= bus.resp_spike;
                        st           <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_mem[idx] <= resp_state_q;
                    if (resp_spike_q) begin
                        st              <= S_EMIT;
                        bus.spike_valid <= 1'b1;
                        bus.spike_id    <= idx;
`ifdef EIF_SCHED_REFRACTORY_EN
                        refr[idx] <= RC_W'(REFRAC_TICKS);
`endif
                    end
                end
                S_EMIT: begin
                    if (bus.spike_ready) begin
                        bus.spike_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase

            if (advance) begin
                if (last) begin
                    st   <= S_DONE;
                    done <= 1'b1;
                end else begin
                    idx             <= nidx;
                    st              <= S_ISSUE;
                    bus.req_valid   <= issue_next;
                    bus.req_state   <= state_mem[nidx];
                    bus.req_current <= cur_mem[nidx];
                end
            end
        end
    end

endmodule

// File: tb/tb_eif_neuron_scheduler.sv
// Self-checking bench for eif_neuron_scheduler. A transaction-level model
// (per-neuron state/current/refractory arrays plus a simple integrate-and-
// fire datapath function) predicts every request, spike event and sweep end.
module tb_eif_neuron_scheduler;

    localparam int N      = 4;
    localparam int IDW    = 2;
    localparam int WW     = 8;
    localparam int UREST  = 50;
    localparam int REFRAC = 2;
    localparam int THRESH = 200;
`ifdef EIF_SCHED_REFRACTORY_EN
    localparam bit REFR_ON = 1'b1;
`else
    localparam bit REFR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic            cur_we;
    logic [IDW-1:0]  cur_addr;
    logic [WW-1:0]   cur_data;
    logic            busy;
    logic            done;
    logic            tick_overrun;

    eif_neuron_scheduler_if #(.ID_W(IDW), .W(WW)) bus ();

    eif_neuron_scheduler #(
        .N_NEURONS    (N),
        .ID_W         (IDW),
        .W            (WW),
        .U_REST       (UREST),
        .REFRAC_TICKS (REFRAC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .cur_we       (cur_we),
        .cur_addr     (cur_addr),
        .cur_data     (cur_data),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int m_state [N];
    int m_cur   [N];
    int m_refr  [N];
    bit m_ovr;
    int seen_state [N];
    bit issued [N];
    int last_cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dp(input int s, input int c, input bit f);
        int sum;
        sum = s + c;
        if (f || sum >= THRESH) return {1'b1, 8'(UREST)};
        return {1'b0, 8'(sum)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = UREST;
            m_cur[i]   = 0;
            m_refr[i]  = 0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_valid"},   bus.req_valid,   0);
        chk({tag, "_req_state"},   bus.req_state,   0);
        chk({tag, "_req_current"}, bus.req_current, 0);
        chk({tag, "_spike_valid"}, bus.spike_valid, 0);
        chk({tag, "_spike_id"},    bus.spike_id,    0);
        chk({tag, "_busy"},        busy,            0);
        chk({tag, "_done"},        done,            0);
        chk({tag, "_overrun"},     tick_overrun,    0);
    endtask

    task automatic idle_write(input int a, input int d);
        cur_we   = 1'b1;
        cur_addr = IDW'(a);
        cur_data = WW'(d);
        @(negedge clk);
        cur_we = 1'b0;
        m_cur[a] = d;
    endtask

    // One sweep driven from a negedge in IDLE; all sampling/driving on negedges.
    task automatic run_sweep(input int lat_max, input int stall_fix, input bit [3:0] force_spk,
                             input bit busy_tick, input bit done_tick, input int abort_at,
                             input bit rnd_wr);
        int cyc, lat, stall, cu, a, d;
        logic [8:0] r;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc = 1;
        chk("busy_start", busy, 1);
        for (int i = 0; i < N; i++) begin
            issued[i] = 1'b0;
            if (m_refr[i] > 0) begin
                chk("skip_no_req", bus.req_valid, 0);
                m_refr[i]--;
                @(negedge clk);
                cyc++;
                continue;
            end
            chk("req_valid", bus.req_valid, 1);
            chk("req_state", bus.req_state, m_state[i]);
            chk("req_current", bus.req_current, m_cur[i]);
            issued[i]     = 1'b1;
            seen_state[i] = bus.req_state;
            cu = m_cur[i];
            r  = dp(m_state[i], cu, force_spk[i]);
            if (busy_tick && i == 1) begin
                tick  = 1'b1;
                m_ovr = 1'b1;
            end
            if (rnd_wr && ($urandom % 4) == 0) begin
                d = int'($urandom_range(0, 60));
                cur_we = 1'b1; cur_addr = IDW'(i); cur_data = WW'(d);
                m_cur[i] = d;
            end
            if (($urandom % 3) == 0) begin
                bus.resp_valid = 1'b1;
                bus.resp_state = WW'($urandom);
                bus.resp_spike = 1'b1;
            end
            lat = int'($urandom_range(1, lat_max));
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                cyc++;
                tick   = 1'b0;
                cur_we = 1'b0;
                if (abort_at == i && k == 1) begin
                    rst = 1'b1;
                    bus.resp_valid = 1'b0;
                    #1;
                    check_reset_vals("abort");
                    model_reset();
                    return;
                end
                if (rnd_wr && k == 1 && ($urandom % 2) == 0) begin
                    a = int'($urandom_range(0, N - 1));
                    d = int'($urandom_range(0, 60));
                    cur_we = 1'b1; cur_addr = IDW'(a); cur_data = WW'(d);
                    m_cur[a] = d;
                end
                chk("wait_no_req", bus.req_valid, 0);
                bus.resp_valid = (k == lat);
                bus.resp_state = (k == lat) ? r[7:0] : WW'($urandom);
                bus.resp_spike = (k == lat) ? r[8] : 1'b0;
            end
            @(negedge clk);
            cyc++;
            cur_we = 1'b0;
            bus.resp_valid = 1'b0;
            chk("write_no_req", bus.req_valid, 0);
            m_state[i] = int'(r[7:0]);
            if (r[8]) begin
                stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
                @(negedge clk);
                cyc++;
                for (int s = 0; s <= stall; s++) begin
                    chk("spike_valid", bus.spike_valid, 1);
                    chk("spike_id", bus.spike_id, i);
                    chk("emit_no_req", bus.req_valid, 0);
                    bus.spike_ready = (s == stall);
                    @(negedge clk);
                    cyc++;
                end
                bus.spike_ready = 1'b0;
                chk("spike_drop", bus.spike_valid, 0);
                if (REFR_ON) m_refr[i] = REFRAC;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        last_cyc = cyc;
        if (done_tick) begin
            tick  = 1'b1;
            m_ovr = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
        chk("done_drop", done, 0);
        chk("busy_drop", busy, 0);
        chk("overrun", tick_overrun, int'(m_ovr));
        if (done_tick) begin
            @(negedge clk);
            chk("dropped_tick_busy", busy, 0);
            chk("dropped_tick_req", bus.req_valid, 0);
        end
    endtask

    initial begin
        bit [3:0] fm;
        int nw;
        rst = 1'b1; tick = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0;
        bus.resp_valid = 1'b0; bus.resp_state = '0; bus.resp_spike = 1'b0;
        bus.spike_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("in_rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_rst");

        // Read-back sweep with zero currents: all states at rest, done at cycle 13.
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_done_cycle", last_cyc, 13);
        for (int i = 0; i < N; i++) chk("lit_rest_state", seen_state[i], 50);

        // Current 20 on neuron 2 integrates to 70; others stay at rest.
        idle_write(2, 20);
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_n2_state", seen_state[2], 70);
        chk("lit_n0_state", seen_state[0], 50);
        chk("lit_n3_state", seen_state[3], 50);

        // Forced spike on neuron 1 with a 5-cycle consumer stall.
        run_sweep(1, 5, 4'b0010, 1'b0, 1'b0, -1, 1'b0);

        // Ticks while busy and in the DONE cycle are dropped.
        run_sweep(1, -1, 4'b0000, 1'b1, 1'b1, -1, 1'b0);
        chk("lit_overrun_set", tick_overrun, 1);
        run_sweep(2, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_overrun_sticky", tick_overrun, 1);

        // Reset while waiting on neuron 2; a late response must be ignored.
        idle_write(0, 33);
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, 2, 1'b0);
        bus.resp_valid = 1'b1; bus.resp_state = 8'hAA; bus.resp_spike = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_resp_busy", busy, 0);
        chk("late_resp_req", bus.req_valid, 0);
        chk("late_resp_spike", bus.spike_valid, 0);
        bus.resp_valid = 1'b0; bus.resp_spike = 1'b0;
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < N; i++) chk("lit_after_abort", seen_state[i], 50);
        chk("lit_after_abort_cur0", m_cur[0], 0);

        // Neuron 0 spikes, then refractory skipping (if enabled) for two sweeps.
        run_sweep(1, 0, 4'b0001, 1'b0, 1'b0, -1, 1'b0);
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_refr_sweep1", issued[0], REFR_ON ? 0 : 1);
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_refr_sweep2", issued[0], REFR_ON ? 0 : 1);
        run_sweep(1, -1, 4'b0000, 1'b0, 1'b0, -1, 1'b0);
        chk("lit_refr_sweep3", issued[0], 1);

        // Randomized sweeps: latencies, stalls, currents, in-flight writes.
        for (int t = 0; t < 16; t++) begin
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) idle_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 60)));
            fm = (($urandom % 5) == 0) ? 4'($urandom) : 4'b0000;
            run_sweep(3, -1, fm, 1'b0, 1'b0, -1, 1'b1);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
